// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_ctrl
//  Purpose  : Bit-serial adder sequencer. One single-bit full-adder cell is
//             time-shared across all WIDTH bit positions, LSB first. Operands
//             are captured on an accepted start. The result (Sum, Cout,
//             signed overflow V) is registered and flagged with a one-cycle
//             done pulse.
//  Ports    : clk    - system clock, rising edge
//             reset  - synchronous, active-high reset
//             start  - request a new addition; sampled only while idle
//             A, B   - WIDTH-bit operands, captured on accepted start
//             Ci     - carry-in, captured on accepted start
//             busy   - high while bits are being processed
//             done   - one-cycle pulse after the result registers update
//             Sum    - registered sum of the last completed addition
//             Cout   - registered unsigned carry-out
//             V      - registered two's-complement overflow
//  Revision : 1.0  initial release
// ============================================================================
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             V
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   part_q;
    logic               carry_q;
    logic [c_CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               v_q;

    logic               w_s;
    logic               w_c;
    logic               w_last;
    logic [WIDTH-1:0]   w_part;

    // Shared full-adder cell working on the current LSB pair.
    assign w_s    = opa_q[0] ^ opb_q[0] ^ carry_q;
    assign w_c    = (opa_q[0] & opb_q[0]) | (carry_q & (opa_q[0] ^ opb_q[0]));
    assign w_last = (cnt_q == c_LAST);
    // New sum bit enters at the top, so after WIDTH shifts bit 0 is at LSB.
    assign w_part = {w_s, part_q[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The unused encoding falls through to IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE: state_d = start ? S_ADD : S_IDLE;
            S_ADD:  state_d = w_last ? S_DONE : S_ADD;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand shifters, carry flop, counter and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            opa_q   <= '0;
            opb_q   <= '0;
            part_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        opa_q   <= A;
                        opb_q   <= B;
                        carry_q <= Ci;
                        cnt_q   <= '0;
                        part_q  <= '0;
                    end
                end
                S_ADD: begin
                    part_q  <= w_part;
                    opa_q   <= opa_q >> 1;
                    opb_q   <= opb_q >> 1;
                    carry_q <= w_c;
                    cnt_q   <= cnt_q + c_CNT_W'(1);
                    if (w_last) begin
                        sum_q  <= w_part;
                        cout_q <= w_c;
                        // Carry into MSB differs from carry out of MSB.
                        v_q    <= carry_q ^ w_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state_q == S_ADD);
    assign done = (state_q == S_DONE);
    assign Sum  = sum_q;
    assign Cout = cout_q;
    assign V    = v_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder_ctrl
//  Purpose  : Self-checking bench for serial_adder_ctrl (WIDTH=8). Expected
//             results come from an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_adder_ctrl;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 40;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             V;

    int n_checks;
    int n_errors;
    int cyc;

    // Model's view of the currently held result registers.
    logic [WIDTH-1:0] held_sum;
    logic             held_cout;
    logic             held_v;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .A    (A),
        .B    (B),
        .Ci   (Ci),
        .busy (busy),
        .done (done),
        .Sum  (Sum),
        .Cout (Cout),
        .V    (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     tag, obs, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned and signed views.
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic ci, output logic [WIDTH-1:0] s,
                         output logic co, output logic v);
        longint          sa;
        longint          sb;
        longint          st;
        longint unsigned u;
        sa = $signed(a);
        sb = $signed(b);
        st = sa + sb + longint'(ci);
        u  = longint'(a) + longint'(b) + longint'(ci);
        s  = u[WIDTH-1:0];
        co = u[WIDTH];
        v  = (st > (2**(WIDTH-1)) - 1) || (st < -(2**(WIDTH-1)));
    endtask

    // One full addition. With disturb set, start is re-pulsed and the
    // operand inputs are scrambled while the addition is in flight.
    task automatic run_add(input string tag, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic ci,
                           input bit disturb);
        logic [WIDTH-1:0] es;
        logic             ec;
        logic             ev;
        int               n;
        int               busy_cnt;
        int               hold_bad;
        model(a, b, ci, es, ec, ev);
        @(negedge clk);
        A = a; B = b; Ci = ci; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0; busy_cnt = 0; hold_bad = 0;
        forever begin
            @(negedge clk);
            n++;
            if (done || n > TIMEOUT) break;
            if (busy) busy_cnt++;
            if (Sum !== held_sum || Cout !== held_cout || V !== held_v)
                hold_bad++;
            if (disturb && n < WIDTH - 1) begin
                start = 1'($urandom_range(0, 1));
                A = WIDTH'($urandom); B = WIDTH'($urandom);
                Ci = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
        end
        check_value({tag, " done_seen"}, 32'(done), 32'd1);
        check_value({tag, " latency"}, n, WIDTH + 1);
        check_value({tag, " busy_cycles"}, busy_cnt, WIDTH);
        check_value({tag, " hold_during_add"}, hold_bad, 0);
        check_value({tag, " Sum"}, 32'(Sum), 32'(es));
        check_value({tag, " Cout"}, 32'(Cout), 32'(ec));
        check_value({tag, " V"}, 32'(V), 32'(ev));
        held_sum = es; held_cout = ec; held_v = ev;
        @(negedge clk);
        check_value({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check_value({tag, " idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int first_done;
        int prev_done;
        int n;
        int ndone;
        int bad;

        n_checks = 0; n_errors = 0;
        reset = 1'b1; start = 1'b0; A = '0; B = '0; Ci = 1'b0;
        held_sum = '0; held_cout = 1'b0; held_v = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("reset busy", 32'(busy), 32'd0);
        check_value("reset done", 32'(done), 32'd0);
        check_value("reset result", {22'd0, Sum, Cout, V}, 32'd0);
        reset = 1'b0;

        // Directed cases
        run_add("t1_5A_3C", 8'h5A, 8'h3C, 1'b0, 1'b0);
        run_add("t2_FF_01", 8'hFF, 8'h01, 1'b0, 1'b0);
        run_add("t2_FF_00_ci", 8'hFF, 8'h00, 1'b1, 1'b0);
        run_add("t3_80_80", 8'h80, 8'h80, 1'b0, 1'b0);
        run_add("t3_hold_next", 8'h12, 8'h34, 1'b0, 1'b0);

        // Re-pulsed start and changed operands mid-add
        @(negedge clk);
        A = 8'h05; B = 8'h03; Ci = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 3 * WIDTH; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                check_value("t4 Sum", 32'(Sum), 32'h08);
                check_value("t4 CoutV", {30'd0, Cout, V}, 32'd0);
            end
            if (i == 2) begin start = 1'b1; A = 8'h11; B = 8'h22; end
            if (i == 4) start = 1'b0;
        end
        check_value("t4 done_pulses", ndone, 1);
        held_sum = 8'h08; held_cout = 1'b0; held_v = 1'b0;

        // Reset during ADD
        @(negedge clk);
        A = 8'hC3; B = 8'h7E; Ci = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_value("t5 busy", 32'(busy), 32'd0);
        check_value("t5 done", 32'(done), 32'd0);
        check_value("t5 result", {22'd0, Sum, Cout, V}, 32'd0);
        held_sum = '0; held_cout = 1'b0; held_v = 1'b0;
        bad = 0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            @(negedge clk);
            if (done || busy) bad++;
        end
        check_value("t5 no_done_after", bad, 0);
        run_add("t5_after_reset", 8'h0F, 8'h01, 1'b0, 1'b0);

        // Randomized runs with in-flight disturbance
        for (int k = 0; k < 20; k++) begin
            run_add("rand", WIDTH'($urandom), WIDTH'($urandom),
                    1'($urandom_range(0, 1)), 1'b1);
        end

        // Start held high: one addition every WIDTH+2 cycles
        @(negedge clk);
        A = 8'h01; B = 8'h01; Ci = 1'b0; start = 1'b1;
        ndone = 0; first_done = -1; prev_done = -1; bad = 0; n = 0;
        while (ndone < 4 && n < 8 * TIMEOUT) begin
            @(negedge clk);
            n++;
            if (done) begin
                if (Sum !== 8'h02 || Cout !== 1'b0 || V !== 1'b0) bad++;
                if (prev_done >= 0 && (cyc - prev_done) != WIDTH + 2) bad++;
                if (first_done < 0) first_done = cyc;
                prev_done = cyc;
                ndone++;
            end
        end
        check_value("t6 pulses", ndone, 4);
        check_value("t6 period_and_sum", bad, 0);

        // Reset dominates start
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy || done) bad++;
        end
        check_value("t6 reset_over_start", bad, 0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_value("t6 idle_after_reset", {30'd0, busy, done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
